// File: rtl/alu_multicycle.sv
// Single-cycle ALU for logic/arith/compare ops plus a shift-add multiplier
// that runs DATA_W steps; results and flags are registered and held between completions.
module alu_multicycle #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [3:0]        ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              overflow_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned CntW = $clog2(DATA_W) + 1;
    localparam logic [CntW-1:0] LastStep = CntW'(DATA_W - 1);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpSlt = 4'b0111;
    localparam logic [3:0] OpNor = 4'b1100;
    localparam logic [3:0] OpMul = 4'b1000;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [DATA_W-1:0] sum, diff, alu_res, addend, acc_sum;
    logic              add_ovf, sub_ovf, slt, alu_ovf;

    // Combinational single-cycle datapath
    always_comb begin
        sum     = src1_i + src2_i;
        diff    = src1_i - src2_i;
        add_ovf = (src1_i[DATA_W-1] == src2_i[DATA_W-1]) &&
                  (sum[DATA_W-1] != src1_i[DATA_W-1]);
        sub_ovf = (src1_i[DATA_W-1] != src2_i[DATA_W-1]) &&
                  (diff[DATA_W-1] != src1_i[DATA_W-1]);
        // Sign of the true difference: flip the wrapped sign bit when subtraction overflowed
        slt     = diff[DATA_W-1] ^ sub_ovf;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ctrl_i)
            OpAnd: alu_res = src1_i & src2_i;
            OpOr:  alu_res = src1_i | src2_i;
            OpAdd: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            OpSub: begin
                alu_res = diff;
                alu_ovf = sub_ovf;
            end
            OpSlt: alu_res = {{(DATA_W-1){1'b0}}, slt};
            OpNor: alu_res = ~(src1_i | src2_i);
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    always_comb begin
        addend  = mplier_q[0] ? mcand_q : '0;
        acc_sum = acc_q + addend;
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start_i) begin
                    if (ctrl_i == OpMul) begin
                        mcand_d  = src1_i;
                        mplier_d = src2_i;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StMul;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        state_d  = StDone;
                    end
                end
            end
            StMul: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastStep) begin
                    result_d = acc_sum;
                    zero_d   = (acc_sum == '0);
                    ovf_d    = 1'b0;
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StMul);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= StIdle;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign overflow_o = ovf_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule
